// File: rtl/warmboot_sequencer_if.sv
// Request/grant and SB_WARMBOOT-facing signals of the warm-boot sequencer.
// The requester side is the master; the sequencer is the slave.
interface warmboot_sequencer_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   REQ;
    logic [2*NREQ-1:0] REQ_IMAGE;
    logic              ABORT;
    logic [NREQ-1:0]   GNT;
    logic              BUSY;
    logic              ARMED;
    logic              BOOT;
    logic              S1;
    logic              S0;

    modport master (
        output REQ, REQ_IMAGE, ABORT,
        input  GNT, BUSY, ARMED, BOOT, S1, S0
    );

    modport slave (
        input  REQ, REQ_IMAGE, ABORT,
        output GNT, BUSY, ARMED, BOOT, S1, S0
    );
endinterface

// File: rtl/warmboot_sequencer.sv
// Round-robin owner of the SB_WARMBOOT primitive: latches the winning image select,
// holds it through an abortable arm window, then pulses BOOT.
//
// state | meaning
// IDLE  | waiting for any REQ bit; round-robin pick on the sampling edge
// ARM   | image select latched and held; HOLD_CYCLES long; ABORT returns to IDLE
// FIRE  | BOOT high for BOOT_PULSE cycles; ABORT/REQ ignored
// DONE  | terminal until RST (device reconfigures in hardware)
module warmboot_sequencer #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 1024,
    parameter int BOOT_PULSE  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    warmboot_sequencer_if.slave  bus
);
    localparam int MAXC = (HOLD_CYCLES > BOOT_PULSE) ? HOLD_CYCLES : BOOT_PULSE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            armed_q;
    logic            boot_q;
    logic            s1_q;
    logic            s0_q;

    logic            win_valid;
    logic [PW-1:0]   win;
    logic [1:0]      win_image;

    // Descending scan so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            automatic int idx;
            idx = (int'(ptr) + i) % NREQ;
            if (bus.REQ[idx[PW-1:0]]) begin
                win_valid = 1'b1;
                win       = idx[PW-1:0];
            end
        end
    end

    assign win_image = bus.REQ_IMAGE[{win, 1'b0} +: 2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= PW'(NREQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
            boot_q  <= 1'b0;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state        <= ST_ARM;
                        gnt_q        <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        ptr          <= win;
                        {s1_q, s0_q} <= win_image;
                        cnt          <= CW'(HOLD_CYCLES - 1);
                        busy_q       <= 1'b1;
                        armed_q      <= 1'b1;
                    end
                end
                ST_ARM: begin
                    // Abort takes priority over the terminal count.
                    if (bus.ABORT) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        armed_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state   <= ST_FIRE;
                        cnt     <= CW'(BOOT_PULSE - 1);
                        armed_q <= 1'b0;
                        boot_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIRE: begin
                    if (cnt == '0) begin
                        state  <= ST_DONE;
                        boot_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.BUSY  = busy_q;
    assign bus.ARMED = armed_q;
    assign bus.BOOT  = boot_q;
    assign bus.S1    = s1_q;
    assign bus.S0    = s0_q;
endmodule
